// File: rtl/barrett_mm_iter_if.sv
// rtl/barrett_mm_iter_if.sv - start/done operand bus of the Barrett modular multiplier
interface barrett_mm_iter_if #(
  parameter int N   = 1024,
  parameter int M_W = 4
);
  logic           start;
  logic [N-1:0]   X;
  logic [N-1:0]   Y;
  logic [N-1:0]   MOD;
  logic [M_W+6:0] MU;
  logic           busy;
  logic           done;
  logic [N-1:0]   Z;

  modport master (output start, X, Y, MOD, MU, input busy, done, Z);
  modport slave  (input start, X, Y, MOD, MU, output busy, done, Z);
endinterface

// File: rtl/barrett_mm_iter.sv
// rtl/barrett_mm_iter.sv - digit-serial carry-save Barrett modular multiplier Z = X*Y mod MOD
module barrett_mm_iter #(
  parameter int N   = 1024,
  parameter int M_W = 4
) (
  input logic              CLK,
  input logic              RST,
  barrett_mm_iter_if.slave bus
);

  localparam int K   = N / M_W;
  localparam int W   = N + M_W + 4;   // carry-save accumulator width
  localparam int HW  = M_W + 6;       // top slice of T used for the estimate (signed)
  localparam int TW  = M_W + 5;       // non-negative part of that slice
  localparam int QW  = M_W + 3;       // quotient digit, q < 5r
  localparam int MUW = M_W + 7;
  localparam int PW  = TW + MUW;
  localparam int CW  = ($clog2(K) > 2) ? $clog2(K) : 2;

  typedef enum logic [2:0] {S_IDLE, S_ITER, S_RESOLVE, S_CORR, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   x_q, x_d, y_q, y_d, mod_q, mod_d, z_q, z_d;
  logic [MUW-1:0] mu_q, mu_d;
  logic [W-1:0]   zs_q, zs_d, zc_q, zc_d;
  logic [N+1:0]   r_q, r_d;

  logic [M_W-1:0]   y_dig;
  logic [N+M_W-1:0] xy;
  logic [W-1:0]     a_sh, b_sh, pp, qm_n, s1, c1, s2, c2;
  logic [HW-1:0]    th_sum;
  logic [TW-1:0]    th;
  logic [PW-1:0]    prod;
  logic [QW-1:0]    q;
  logic [N+QW-1:0]  qmod;
  logic [N+1:0]     mod_ext, r_sub, r_corr;
  logic             unused_prod;

  // One Barrett digit step: T = (ZS+ZC)*r + X*y_j, q from the top of T, then T - q*MOD in carry-save
  always_comb begin
    y_dig  = y_q[N-1 -: M_W];
    a_sh   = zs_q << M_W;
    b_sh   = zc_q << M_W;
    xy     = {{M_W{1'b0}}, x_q} * {{N{1'b0}}, y_dig};
    pp     = {4'b0000, xy};
    // Summing the three truncated slices undershoots by at most 2 and may wrap below zero
    th_sum = a_sh[W-1 -: HW] + b_sh[W-1 -: HW] + pp[W-1 -: HW];
    th     = th_sum[HW-1] ? '0 : th_sum[TW-1:0];
    prod   = {{MUW{1'b0}}, th} * {{TW{1'b0}}, mu_q};
    q      = prod[MUW +: QW];
    unused_prod = ^{prod[PW-1:MUW+QW], prod[MUW-1:0]};
    qmod   = {{QW{1'b0}}, mod_q} * {{N{1'b0}}, q};
    qm_n   = ~{1'b0, qmod};
    s1     = a_sh ^ b_sh ^ pp;
    c1     = ((a_sh & b_sh) | (a_sh & pp) | (b_sh & pp)) << 1;
    s2     = s1 ^ c1 ^ qm_n;
    // The +1 completing the two's-complement of q*MOD rides in the free carry LSB
    c2     = (((s1 & c1) | (s1 & qm_n) | (c1 & qm_n)) << 1) | {{(W-1){1'b0}}, 1'b1};
    mod_ext = {2'b00, mod_q};
    r_sub   = r_q - mod_ext;
    r_corr  = (r_q >= mod_ext) ? r_sub : r_q;
  end

  // Sequencer: accept, iterate K digits, resolve, three fixed corrections, done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    mod_d   = mod_q;
    mu_d    = mu_q;
    zs_d    = zs_q;
    zc_d    = zc_q;
    r_d     = r_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          x_d     = bus.X;
          y_d     = bus.Y;
          mod_d   = bus.MOD;
          mu_d    = bus.MU;
          zs_d    = '0;
          zc_d    = '0;
          cnt_d   = CW'(K - 1);
          state_d = S_ITER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        zs_d  = s2;
        zc_d  = c2;
        y_d   = y_q << M_W;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        r_d     = zs_q[N+1:0] + zc_q[N+1:0];
        cnt_d   = '0;
        state_d = S_CORR;
      end
      S_CORR: begin
        r_d   = r_corr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(2)) begin
          z_d     = r_corr[N-1:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mod_q   <= '0;
      mu_q    <= '0;
      zs_q    <= '0;
      zc_q    <= '0;
      r_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mod_q   <= mod_d;
      mu_q    <= mu_d;
      zs_q    <= zs_d;
      zc_q    <= zc_d;
      r_q     <= r_d;
      z_q     <= z_d;
    end
  end

  // The resolved remainder must be below 4*MOD or three corrections cannot finish it
  always_ff @(posedge CLK) begin
    if (!RST && state_q == S_RESOLVE) assert (r_d < {mod_q, 2'b00});
  end

  assign bus.busy = (state_q == S_ITER) || (state_q == S_RESOLVE) || (state_q == S_CORR);
  assign bus.done = (state_q == S_DONE);
  assign bus.Z    = z_q;

endmodule
